// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt request-capture stage.
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_IDXW = 3;

    typedef logic [IRQ_N-1:0]    irq_vec_t;
    typedef logic [IRQ_IDXW-1:0] irq_idx_t;

endpackage : irq_pkg

// File: rtl/sync_edge_detect.sv
// Vectorised synchroniser chain plus previous-value flop per line.
// rise is high for one cycle when the synchronised line goes 0 -> 1.
module sync_edge_detect
    import irq_pkg::*;
#(
    parameter int W           = IRQ_N,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] s_s;
    logic [W-1:0] prev_r;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            // Input is already synchronous to clk.
            assign s_s = d;
        end else begin : g_sync
            logic [W-1:0] chain_r [SYNC_STAGES];

            // Shift raw requests through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        chain_r[i] <= {W{1'b0}};
                    end
                end else begin
                    chain_r[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain_r[i] <= chain_r[i-1];
                    end
                end
            end

            assign s_s = chain_r[SYNC_STAGES-1];
        end
    endgenerate

    // Remember last cycle's synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r <= {W{1'b0}};
        end else begin
            prev_r <= s_s;
        end
    end

    assign rise = s_s & ~prev_r;

endmodule : sync_edge_detect

// File: rtl/irq_pending_latch.sv
// Request-capture stage feeding the 8-to-3 priority encoder: synchronises
// request lines, latches rising edges as sticky pending bits cleared by
// indexed acknowledge, masks the result and reports overflow / stray acks.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int IDXW        = IRQ_IDXW,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic            mask_wr,
    input  logic [N-1:0]    mask_din,
    input  logic            ack,
    input  logic [IDXW-1:0] ack_idx,
    input  logic            ovf_clr,
    output logic [N-1:0]    pending_out,
    output logic            irq,
    output logic [N-1:0]    overflow,
    output logic            ack_err
);

    logic [N-1:0] rise_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] pend_next_s;
    logic [N-1:0] mask_next_s;
    logic [N-1:0] ovf_next_s;
    logic [N-1:0] pout_next_s;
    logic         ack_err_next_s;

    logic [N-1:0] pend_r;
    logic [N-1:0] mask_r;
    logic [N-1:0] ovf_r;
    logic [N-1:0] pending_out_r;
    logic         irq_r;
    logic         ack_err_r;

    sync_edge_detect #(
        .W           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_in),
        .rise  (rise_s)
    );

    // Decode the acknowledge index into a one-hot clear; out-of-range
    // indices decode to nothing, which also flags them as stray below.
    always_comb begin
        clr_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (ack && (ack_idx == IDXW'(i))) begin
                clr_s[i] = 1'b1;
            end else begin
                clr_s[i] = 1'b0;
            end
        end
    end

    // Next-state for pending, mask, overflow and the registered outputs.
    // A new edge beats a clear so a collision never loses the event.
    always_comb begin
        pend_next_s = (pend_r & ~clr_s) | rise_s;
        if (mask_wr) begin
            mask_next_s = mask_din;
        end else begin
            mask_next_s = mask_r;
        end
        ovf_next_s = ovf_r;
        if (ovf_clr) begin
            ovf_next_s = {N{1'b0}};
        end else begin
            ovf_next_s = ovf_r;
        end
        ovf_next_s     = ovf_next_s | (rise_s & pend_r & ~clr_s);
        pout_next_s    = pend_next_s & mask_next_s;
        // Stray-ack check uses the currently visible (old-mask) vector.
        ack_err_next_s = ack & ~(|(clr_s & pending_out_r));
    end

    // State and output registers; reset discards events and reopens the mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r        <= {N{1'b0}};
            mask_r        <= {N{1'b1}};
            ovf_r         <= {N{1'b0}};
            pending_out_r <= {N{1'b0}};
            irq_r         <= 1'b0;
            ack_err_r     <= 1'b0;
        end else begin
            pend_r        <= pend_next_s;
            mask_r        <= mask_next_s;
            ovf_r         <= ovf_next_s;
            pending_out_r <= pout_next_s;
            irq_r         <= |pout_next_s;
            ack_err_r     <= ack_err_next_s;
        end
    end

    assign pending_out = pending_out_r;
    assign irq         = irq_r;
    assign overflow    = ovf_r;
    assign ack_err     = ack_err_r;

endmodule : irq_pending_latch

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench: directed vector table with hand-derived expectations,
// then randomized traffic checked against an event-level reference model.
module tb_irq_pending_latch;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pending_out;
    logic       irq;
    logic [7:0] overflow;
    logic       ack_err;

    int n_vec;
    int n_err;

    irq_pending_latch #(.N(8), .IDXW(3), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask_wr     (mask_wr),
        .mask_din    (mask_din),
        .ack         (ack),
        .ack_idx     (ack_idx),
        .ovf_clr     (ovf_clr),
        .pending_out (pending_out),
        .irq         (irq),
        .overflow    (overflow),
        .ack_err     (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (event level) ----------------
    // hist[k] = request value sampled k+1 edges ago (zero across reset).
    logic [7:0] hist [3];
    logic [7:0] m_pend, m_mask, m_ovf, m_pout;
    logic       m_irq, m_err;

    task automatic model_edge();
        logic [7:0] ev;
        logic       cleared;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k] = 8'h00;
            m_pend = 8'h00; m_mask = 8'hFF; m_ovf = 8'h00;
            m_pout = 8'h00; m_irq = 1'b0; m_err = 1'b0;
        end else begin
            ev = hist[1] & ~hist[2];     // line seen rising two stages deep
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = req_in;
            m_err = ack && (m_pout[ack_idx] == 1'b0);
            if (ovf_clr) m_ovf = 8'h00;
            for (int i = 0; i < 8; i++) begin
                cleared = ack && (int'(ack_idx) == i);
                if (ev[i] && m_pend[i] && !cleared) m_ovf[i] = 1'b1;
                if (ev[i])        m_pend[i] = 1'b1;
                else if (cleared) m_pend[i] = 1'b0;
            end
            if (mask_wr) m_mask = mask_din;
            m_pout = m_pend & m_mask;
            m_irq  = (m_pout != 8'h00);
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update model with the driven inputs, then compare #1 later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_pending", pending_out, m_pout);
        check("model_irq", {7'd0, irq}, {7'd0, m_irq});
        check("model_overflow", overflow, m_ovf);
        check("model_ack_err", {7'd0, ack_err}, {7'd0, m_err});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       mwr;
        logic [7:0] mdin;
        logic       ack;
        logic [2:0] idx;
        logic       oclr;
        logic [7:0] e_pend;
        logic       e_irq;
        logic [7:0] e_ovf;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic [7:0] req, logic mwr, logic [7:0] mdin,
                               logic a, logic [2:0] idx, logic oclr,
                               logic [7:0] ep, logic ei, logic [7:0] eo, logic ee);
        vec_t t;
        t.rst = rst; t.req = req; t.mwr = mwr; t.mdin = mdin; t.ack = a;
        t.idx = idx; t.oclr = oclr; t.e_pend = ep; t.e_irq = ei; t.e_ovf = eo; t.e_err = ee;
        return t;
    endfunction

    initial begin
        logic [31:0] r;
        logic [7:0]  req_q;
        int          hi;

        rst_n = 1'b0; req_in = 8'h00; mask_wr = 1'b0; mask_din = 8'h00;
        ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
        n_vec = 0; n_err = 0;
        for (int k = 0; k < 3; k++) hist[k] = 8'h00;

        // reset
        tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // single event, three-edge latency, then ack 4
        tbl.push_back(v(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h10, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // encoder chain: 81, ack 7, ack 0
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h81, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // mask 7F, bit 7 event hidden, unmask reveals it next cycle
        tbl.push_back(v(1'b1, 8'h01, 1'b1, 8'h7F, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // overflow on bit 2, then ack colliding with a third edge, then clear
        tbl.push_back(v(1'b1, 8'h85, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h85, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h85, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 8'h04, 1'b1, 8'h04, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // stray ack pulses for one cycle
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1));
        tbl.push_back(v(1'b1, 8'h81, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        // build 3C, reset mid-run, lines held high give one event, mask FF
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h3C, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b0, 8'hBD, 1'b1, 8'h00, 1'b1, 3'd3, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'hBD, 1'b1, 8'h00, 1'b0));
        tbl.push_back(v(1'b1, 8'hBD, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 8'h3D, 1'b1, 8'h00, 1'b0));

        @(negedge clk);
        for (int n = 0; n < tbl.size(); n++) begin
            rst_n = tbl[n].rst; req_in = tbl[n].req; mask_wr = tbl[n].mwr;
            mask_din = tbl[n].mdin; ack = tbl[n].ack; ack_idx = tbl[n].idx;
            ovf_clr = tbl[n].oclr;
            step();
            check("tbl_pending", pending_out, tbl[n].e_pend);
            check("tbl_irq", {7'd0, irq}, {7'd0, tbl[n].e_irq});
            check("tbl_overflow", overflow, tbl[n].e_ovf);
            check("tbl_ack_err", {7'd0, ack_err}, {7'd0, tbl[n].e_err});
        end

        // ---------------- randomized traffic ----------------
        rst_n = 1'b0; req_in = 8'h00; mask_wr = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
        step();
        req_q = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            req_q   = req_q ^ (r[7:0] & r[15:8]);
            rst_n   = ($urandom_range(0, 199) != 0);
            req_in  = req_q;
            mask_wr = ($urandom_range(0, 19) == 0);
            mask_din = 8'($urandom);
            ovf_clr = ($urandom_range(0, 24) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            hi = -1;
            for (int i = 0; i < 8; i++) if (m_pout[i]) hi = i;
            if (hi >= 0 && r[16]) ack_idx = 3'(hi);
            else                  ack_idx = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_irq_pending_latch
